// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end for a word memory with sub-word
// read-modify-write stores, load sign/zero extension and alignment rejection.
module mem_access_unit #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] MemWriteData,
    input  logic [DATA_W-1:0] ReadData
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
    state_t state, state_nx;
    logic wr, uns, err, req_err, rd_done;
    logic [1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, word, loaded, merged, mask, ins;
    logic [7:0] cnt, lane_b;
    logic [15:0] lane_h;

    assign req_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign rd_done = state == RD && cnt == 8'(MEM_RD_LAT);

    always_ff @(posedge clock or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = req_err ? RESP : (req_write && req_size == 2'b10) ? WR : RD;
            end
            RD: begin
                MemRead = 1'b1;
                if (rd_done) state_nx = wr ? WR : RESP;
            end
            WR: begin
                MemWrite = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
        endcase
    end

    // Half requests are aligned, so addr[1:0]*8 is also the correct half-lane offset.
    assign lane_b = ReadData[{addr[1:0], 3'b000} +: 8];
    assign lane_h = ReadData[{addr[1], 4'b0000} +: 16];
    assign loaded = size == 2'b00 ? {{24{~uns & lane_b[7]}}, lane_b} :
                    size == 2'b01 ? {{16{~uns & lane_h[15]}}, lane_h} : ReadData;
    assign mask   = size == 2'b00 ? 32'h0000_00FF << {addr[1:0], 3'b000} :
                                    32'h0000_FFFF << {addr[1], 4'b0000};
    assign ins    = size == 2'b00 ? {4{wdata[7:0]}} : {2{wdata[15:0]}};
    assign merged = (ReadData & ~mask) | (ins & mask);

    assign Address      = (MemRead || MemWrite) ? {addr[ADDR_W-1:2], 2'b00} : '0;
    assign MemWriteData = MemWrite ? word : '0;
    assign resp_rdata   = (resp_valid && !wr && !err) ? word : '0;
    assign resp_err     = resp_valid && err;

    // word holds the store data for word stores, the merged word for sub-word
    // stores and the extended result for loads.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr    <= 1'b0;
            uns   <= 1'b0;
            err   <= 1'b0;
            size  <= '0;
            addr  <= '0;
            wdata <= '0;
            word  <= '0;
            cnt   <= '0;
        end else if (state == IDLE && req_valid) begin
            wr    <= req_write;
            uns   <= req_unsigned;
            err   <= req_err;
            size  <= req_size;
            addr  <= req_addr;
            wdata <= req_wdata;
            word  <= (req_write && !req_err) ? req_wdata : '0;
            cnt   <= '0;
        end else if (state == RD) begin
            cnt <= cnt + 8'd1;
            if (rd_done) word <= wr ? merged : loaded;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store sequences against a byte-level
// reference memory and a per-cycle latency schedule for the handshake outputs.
module tb_mem_access_unit;
    logic clock = 1'b0, reset = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [1:0] req_size = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic req_ready, resp_valid, resp_err, MemRead, MemWrite;
    logic [31:0] resp_rdata, MemWriteData, ReadData;
    logic [7:0] Address;
    int compared = 0, mismatched = 0;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
        .MemWriteData(MemWriteData), .ReadData(ReadData)
    );

    // Memory environment: one-cycle registered read, write on the edge.
    logic [31:0] mem [64];
    logic [31:0] rd_q;
    logic pl_en = 1'b0;
    logic [5:0] pl_idx = 6'd0;
    logic [31:0] pl_val = 32'h0;
    assign ReadData = rd_q;
    always @(posedge clock) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        if (MemWrite) mem[Address[7:2]] <= MemWriteData;
        if (MemRead) rd_q <= mem[Address[7:2]];
    end

    // Reference model: byte-addressed memory and the expected transaction.
    logic [7:0] ref_mem [256];
    logic active = 1'b0, m_err = 1'b0, last_err;
    int kind = 0, t0 = 0, cyc = 0;
    logic [7:0] m_addr = 8'h0;
    logic [31:0] m_rdata = 32'h0, m_word = 32'h0, last_rdata;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [76:0] act, input logic [76:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // kind: 0 error, 1 word store, 2 load, 3 sub-word store; response starts at k = kind+1
    always @(negedge clock) begin
        int k;
        logic e_rd, e_wr, e_rv;
        if (!reset) begin
            chk("reset_outs", {MemRead, MemWrite, resp_valid, resp_err, Address, MemWriteData, resp_rdata}, '0);
        end else if (!active) begin
            chk("idle_outs", {req_ready, MemRead, MemWrite, resp_valid, resp_err, Address, MemWriteData, resp_rdata},
                {1'b1, 76'b0});
        end else begin
            k    = cyc - t0;
            e_rd = kind >= 2 && (k == 1 || k == 2);
            e_wr = (kind == 1 && k == 1) || (kind == 3 && k == 3);
            e_rv = k >= kind + 1;
            chk("cycle_outs", {req_ready, MemRead, MemWrite, resp_valid, resp_err, Address, MemWriteData, resp_rdata},
                {1'b0, e_rd, e_wr, e_rv, e_rv & m_err, (e_rd | e_wr) ? {m_addr[7:2], 2'b00} : 8'h00,
                 e_wr ? m_word : 32'h0, e_rv ? m_rdata : 32'h0});
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) ref_mem[8'(a + i)] = w[8*i +: 8];
        pl_en = 1'b1; pl_idx = a[7:2]; pl_val = w;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                       input logic [31:0] d, input int hold);
        int n;
        logic [7:0] b;
        logic [63:0] v;
        m_addr = a; m_rdata = 32'h0; m_word = 32'h0;
        m_err = sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        kind = m_err ? 0 : (w && sz == 2'b10) ? 1 : !w ? 2 : 3;
        if (!m_err) begin
            n = 1 << sz;
            b = {a[7:2], 2'b00};
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = d[8*i +: 8];
                m_word = {ref_mem[8'(b + 3)], ref_mem[8'(b + 2)], ref_mem[8'(b + 1)], ref_mem[b]};
            end else begin
                v = 64'h0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_mem[8'(a + i)]) << (8 * i));
                if (!u && v[8*n-1]) v = v | (~64'h0 << (8 * n));
                m_rdata = v[31:0];
            end
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        @(posedge clock); #1;
        t0 = cyc - 1; active = 1'b1;
        req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_unsigned = ~u; req_addr = ~a; req_wdata = ~d;
        repeat (kind + hold) @(posedge clock);
        #1 resp_ready = 1'b1;
        #1 last_rdata = resp_rdata; last_err = resp_err;
        @(posedge clock); #1;
        resp_ready = 1'b0; active = 1'b0;
        if (w && !m_err) chk("mem_word", mem[a[7:2]], m_word);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_zero", {resp_valid, resp_err, MemRead, MemWrite, Address, MemWriteData, resp_rdata}, 0);

        preload(8'h0C, 32'h0);
        txn(1'b1, 2'b10, 1'b0, 8'h0C, 32'h0000_0009, 0);
        chk("t1_mem", mem[3], 32'h0000_0009);
        txn(1'b0, 2'b10, 1'b0, 8'h0C, 32'h0, 0);
        chk("t1_load", {last_err, last_rdata}, {1'b0, 32'h0000_0009});

        preload(8'h18, 32'h1122_3344);
        txn(1'b1, 2'b00, 1'b0, 8'h1A, 32'h5555_55AB, 0);
        chk("t2_model", m_word, 32'h11AB_3344);
        chk("t2_mem", mem[6], 32'h11AB_3344);
        txn(1'b1, 2'b01, 1'b0, 8'h18, 32'hAAAA_BEEF, 0);
        chk("t2_half_mem", mem[6], 32'h11AB_BEEF);

        preload(8'h04, 32'h0000_80F0);
        txn(1'b0, 2'b00, 1'b0, 8'h04, 32'h0, 0);
        chk("t3_bs", last_rdata, 32'hFFFF_FFF0);
        txn(1'b0, 2'b00, 1'b1, 8'h04, 32'h0, 0);
        chk("t3_bu", last_rdata, 32'h0000_00F0);
        txn(1'b0, 2'b01, 1'b0, 8'h04, 32'h0, 0);
        chk("t3_hs", last_rdata, 32'hFFFF_80F0);
        txn(1'b0, 2'b01, 1'b1, 8'h04, 32'h0, 0);
        chk("t3_hu", last_rdata, 32'h0000_80F0);
        txn(1'b0, 2'b00, 1'b0, 8'h05, 32'h0, 0);
        chk("t3_b1s", last_rdata, 32'hFFFF_FF80);

        txn(1'b1, 2'b01, 1'b0, 8'h05, 32'h1234, 0);
        chk("t4_half_err", {last_err, last_rdata}, {1'b1, 32'h0});
        txn(1'b0, 2'b10, 1'b0, 8'h1E, 32'h0, 0);
        chk("t4_word_err", last_err, 1);
        txn(1'b0, 2'b11, 1'b0, 8'h00, 32'h0, 0);
        chk("t4_size_err", last_err, 1);
        chk("t4_mem", mem[1], 32'h0000_80F0);

        txn(1'b0, 2'b10, 1'b0, 8'h18, 32'h0, 5);
        chk("t5_held", last_rdata, 32'h11AB_BEEF);
        txn(1'b1, 2'b10, 1'b0, 8'h30, 32'hDEAD_BEEF, 3);
        chk("t5_next", mem[12], 32'hDEAD_BEEF);

        preload(8'h20, 32'hCAFE_F00D);
        kind = 3; m_addr = 8'h21; m_err = 1'b0; m_word = 32'h0; m_rdata = 32'h0;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 8'h21; req_wdata = 32'h77;
        @(posedge clock); #1;
        t0 = cyc - 1; active = 1'b1; req_valid = 1'b0;
        @(negedge clock); #1;
        reset = 1'b0; active = 1'b0;
        #1 chk("t6_abort", {MemRead, MemWrite, resp_valid, Address}, 0);
        repeat (2) @(negedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        chk("t6_mem", mem[8], 32'hCAFE_F00D);
        txn(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 0);
        chk("t6_reread", last_rdata, 32'hCAFE_F00D);

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
